pixel_seq_ctrl: RTL and testbench
=================================

# pixel_seq_ctrl

Parametrised photodiode-array sequencer: the successor to the fixed 12-pixel switch control in the local-binary-pattern front end. It replaces software bit-banging of the reset, sample-hold and compare strobes with a programmable frame state machine. Per frame it resets and integrates the array, samples a selectable centre pixel, then compares every enabled neighbour against it via the shared comparator, assembling an NUM_PD-bit code. It sits between the wishbone register block (configuration, code readback) and the analog SystemLevel/PD macros.

## Interface
- NUM_PD, 12: photodiode channels (2..32).
- CNT_W, 16: width of phase-duration fields.
- IDX_W, $clog2(NUM_PD): centre-index width.
- wb_clk_i  in  1  clock.
- wb_rst_n_i  in  1  reset; asynchronous, active-low.
- start_i  in  1  frame request pulse.
- abort_i  in  1  abandon current frame.
- cont_i  in  1  continuous mode (auto-restart after DONE).
- t_rst_i, t_int_i, t_sh_i, t_cmp_i  in  CNT_W each  phase durations in cycles (0 treated as 1).
- center_i  in  IDX_W  reference pixel index (values ≥NUM_PD treated as 0).
- chan_mask_i  in  NUM_PD  neighbour enable.
- cmp_i  in  1  comparator output (asynchronous to clock).
- code_ack_i  in  1  software has read the code.
- sh_rst_o, sh_o, sh_cmp_o, sw1_o, sw2_o  out  1 each  analog strobes.
- pd_a_o, pd_b_o  out  NUM_PD  one-hot pixel selects (ref bus / compare bus).
- lbp_code_o  out  NUM_PD  last completed code.
- code_valid_o  out  1  one-cycle pulse per completed frame.
- code_pend_o  out  1  code not yet acked.
- overrun_o  out  1  sticky, code overwritten before ack.
- busy_o  out  1  state ≠ IDLE.

## Operation
- States: IDLE, RESET, INTEG, SAMPLE, SEL, LATCH, DONE. Config inputs sampled into shadow registers on leaving IDLE; changes mid-frame have no effect.
- IDLE: start_i → RESET. Start while busy ignored.
- RESET: sh_rst_o=1, pd_a_o all ones; t_rst cycles → INTEG.
- INTEG: all strobes 0; t_int cycles → SAMPLE.
- SAMPLE: pd_a_o=one-hot(center), sw1_o=1, sh_o=1; t_sh cycles → SEL with index = lowest enabled neighbour; if none → DONE.
- SEL: pd_a_o=one-hot(center), pd_b_o=one-hot(index), sw2_o=1, sh_cmp_o=1; t_cmp cycles → LATCH.
- LATCH: code bit[index] ← cmp_i (synchronised per Configuration); 1 cycle; next enabled index ascending → SEL, else → DONE.
- DONE: lbp_code_o ← working code, code_valid_o=1, code_pend_o=1; → RESET if cont_i (shadowed) else IDLE.
- Neighbour set = chan_mask & ~one-hot(center). Centre and masked bits always 0 in code.
- Working code cleared on entering RESET; lbp_code_o changes only in DONE.
- abort_i: any non-IDLE state → IDLE next edge; all strobes/selects 0 that edge; no code_valid; lbp_code_o unchanged. abort wins over start same cycle.
- Overrun: DONE while code_pend_o=1 and code_ack_i=0 → overrun_o=1 (sticky). code_ack_i clears code_pend_o and overrun_o; ack coincident with DONE: pend stays 1, overrun not set.

## Timing
- Reset values: all outputs 0, state IDLE, shadows 0.
- start_i at edge n → busy_o and sh_rst_o high after edge n.
- Frame length (K enabled neighbours, L = LATCH cycles): max(t_rst,1)+max(t_int,1)+max(t_sh,1)+K·(max(t_cmp,1)+L)+1.
- Strobes registered; no glitches; exactly one pd_b bit high in SEL/LATCH.
- Continuous mode: DONE directly followed by RESET, zero idle cycles.
- Reset asserted mid-frame: all outputs 0 immediately (asynchronous).

## Configuration
- PIXSEQ_CMP_SYNC_EN defined: cmp_i passes a 2-flop synchroniser; LATCH lasts 3 cycles (L=3), bit taken on the last one.
- Undefined: cmp_i sampled directly; LATCH 1 cycle (L=1). For simulation/bench with synchronous comparator only.

## Test plan
- NUM_PD=12, center=4, mask=0xFFF, t_*=2, cmp_i=1 in SEL for idx 0,5,11 only → lbp_code=0x821, valid pulse once, frame length 2+2+2+11·(2+L)+1.
- mask=0x010, center=4 → SAMPLE goes straight to DONE, code 0x000, no SEL, pd_b_o never nonzero.
- cont_i=1, no ack for two frames → overrun_o=1 after second DONE; code_ack_i → pend and overrun 0.
- abort_i in third SEL → next cycle IDLE, all strobes 0, lbp_code unchanged, no valid.
- t_* all 0 → each phase 1 cycle; center_i=15 with NUM_PD=12 → center treated as 0.
- wb_rst_n_i low during SEL → all outputs 0 asynchronously; after release, start_i runs a full frame correctly.

Source files
------------

// File: rtl/pixel_seq_ctrl_if.sv
// Code readback handshake between the pixel sequencer (master) and the
// register block (slave): completed LBP code, status flags and acknowledge.
interface pixel_seq_ctrl_if #(
    parameter int NUM_PD = 12
) ();
    logic [NUM_PD-1:0] lbp_code_o;
    logic              code_valid_o;
    logic              code_pend_o;
    logic              overrun_o;
    logic              code_ack_i;

    modport master (
        output lbp_code_o, code_valid_o, code_pend_o, overrun_o,
        input  code_ack_i
    );

    modport slave (
        input  lbp_code_o, code_valid_o, code_pend_o, overrun_o,
        output code_ack_i
    );
endinterface

// File: rtl/pixel_seq_ctrl.sv
// Photodiode-array frame sequencer: reset, integrate, sample centre, compare each
// enabled neighbour. Optional macro PIXSEQ_CMP_SYNC_EN adds a 2-flop cmp_i synchroniser.
module pixel_seq_ctrl #(
    parameter int NUM_PD = 12,
    parameter int CNT_W  = 16,
    parameter int IDX_W  = $clog2(NUM_PD)
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               cont_i,
    input  logic [CNT_W-1:0]   t_rst_i,
    input  logic [CNT_W-1:0]   t_int_i,
    input  logic [CNT_W-1:0]   t_sh_i,
    input  logic [CNT_W-1:0]   t_cmp_i,
    input  logic [IDX_W-1:0]   center_i,
    input  logic [NUM_PD-1:0]  chan_mask_i,
    input  logic               cmp_i,
    output logic               sh_rst_o,
    output logic               sh_o,
    output logic               sh_cmp_o,
    output logic               sw1_o,
    output logic               sw2_o,
    output logic [NUM_PD-1:0]  pd_a_o,
    output logic [NUM_PD-1:0]  pd_b_o,
    output logic               busy_o,
    pixel_seq_ctrl_if.master   code_if
);

    typedef enum logic [2:0] {
        S_IDLE, S_RESET, S_INTEG, S_SAMPLE, S_SEL, S_LATCH, S_DONE
    } state_e;

`ifdef PIXSEQ_CMP_SYNC_EN
    localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(2);
    logic [1:0] cmp_sync_q;
    logic       cmp_s;
    assign cmp_s = cmp_sync_q[1];
`else
    localparam logic [CNT_W-1:0] LATCH_LOAD = '0;
    logic       cmp_s;
    assign cmp_s = cmp_i;
`endif

    // Phase counters load duration-1 so a zero duration still lasts one cycle.
    function automatic logic [CNT_W-1:0] dur(input logic [CNT_W-1:0] t);
        return (t == '0) ? '0 : t - CNT_W'(1);
    endfunction

    function automatic logic [NUM_PD-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [NUM_PD-1:0] oh;
        for (int k = 0; k < NUM_PD; k++) oh[k] = (int'(i) == k);
        return oh;
    endfunction

    function automatic logic find_next(input logic [NUM_PD-1:0] m, input int from,
                                       output logic [IDX_W-1:0] idx);
        logic found;
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_PD - 1; k >= 0; k--) begin
            if (m[k] && k >= from) begin
                found = 1'b1;
                idx   = IDX_W'(k);
            end
        end
        return found;
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  t_rst_q, t_rst_d, t_int_q, t_int_d, t_sh_q, t_sh_d, t_cmp_q, t_cmp_d;
    logic              cont_q, cont_d;
    logic [IDX_W-1:0]  center_q, center_d, idx_q, idx_d;
    logic [NUM_PD-1:0] nbr_q, nbr_d, code_q, code_d;
    logic              sh_rst_q, sh_rst_d, sh_q, sh_d, sh_cmp_q, sh_cmp_d;
    logic              sw1_q, sw1_d, sw2_q, sw2_d, busy_q, busy_d;
    logic [NUM_PD-1:0] pd_a_q, pd_a_d, pd_b_q, pd_b_d, lbp_code_q, lbp_code_d;
    logic              code_valid_q, code_valid_d, code_pend_q, code_pend_d;
    logic              overrun_q, overrun_d;

    logic              phase_end, first_found, next_found;
    logic [IDX_W-1:0]  first_idx, next_idx, center_eff;

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d  = state_q;
        cnt_d    = (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);
        t_rst_d  = t_rst_q;
        t_int_d  = t_int_q;
        t_sh_d   = t_sh_q;
        t_cmp_d  = t_cmp_q;
        cont_d   = cont_q;
        center_d = center_q;
        nbr_d    = nbr_q;
        idx_d    = idx_q;
        code_d   = code_q;

        phase_end   = (cnt_q == '0);
        center_eff  = (32'(center_i) >= NUM_PD) ? '0 : center_i;
        first_found = find_next(nbr_q, 0, first_idx);
        next_found  = find_next(nbr_q, int'(idx_q) + 1, next_idx);

        unique case (state_q)
            S_IDLE: if (start_i && !abort_i) begin
                state_d  = S_RESET;
                cnt_d    = dur(t_rst_i);
                t_rst_d  = t_rst_i;
                t_int_d  = t_int_i;
                t_sh_d   = t_sh_i;
                t_cmp_d  = t_cmp_i;
                cont_d   = cont_i;
                center_d = center_eff;
                nbr_d    = chan_mask_i & ~onehot(center_eff);
                code_d   = '0;
            end
            S_RESET: if (phase_end) begin
                state_d = S_INTEG;
                cnt_d   = dur(t_int_q);
            end
            S_INTEG: if (phase_end) begin
                state_d = S_SAMPLE;
                cnt_d   = dur(t_sh_q);
            end
            S_SAMPLE: if (phase_end) begin
                state_d = first_found ? S_SEL : S_DONE;
                idx_d   = first_idx;
                cnt_d   = dur(t_cmp_q);
            end
            S_SEL: if (phase_end) begin
                state_d = S_LATCH;
                cnt_d   = LATCH_LOAD;
            end
            S_LATCH: if (phase_end) begin
                code_d[idx_q] = cmp_s;
                state_d       = next_found ? S_SEL : S_DONE;
                idx_d         = next_idx;
                cnt_d         = dur(t_cmp_q);
            end
            S_DONE: begin
                state_d = cont_q ? S_RESET : S_IDLE;
                cnt_d   = dur(t_rst_q);
                code_d  = '0;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort_i && state_q != S_IDLE) state_d = S_IDLE;

        // Outputs decode the next state so they are registered alongside it.
        sh_rst_d     = (state_d == S_RESET);
        sh_d         = (state_d == S_SAMPLE);
        sw1_d        = (state_d == S_SAMPLE);
        sh_cmp_d     = (state_d == S_SEL);
        sw2_d        = (state_d == S_SEL) || (state_d == S_LATCH);
        busy_d       = (state_d != S_IDLE);
        code_valid_d = (state_d == S_DONE);
        pd_a_d       = '0;
        pd_b_d       = '0;
        if (state_d == S_RESET) pd_a_d = '1;
        if (state_d == S_SAMPLE || sw2_d) pd_a_d = onehot(center_d);
        if (sw2_d) pd_b_d = onehot(idx_d);

        lbp_code_d  = code_valid_d ? code_d : lbp_code_q;
        code_pend_d = code_pend_q;
        overrun_d   = overrun_q;
        if (code_valid_d) begin
            code_pend_d = 1'b1;
            overrun_d   = code_if.code_ack_i ? 1'b0 : (overrun_q | code_pend_q);
        end else if (code_if.code_ack_i) begin
            code_pend_d = 1'b0;
            overrun_d   = 1'b0;
        end
    end

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            t_rst_q      <= '0;
            t_int_q      <= '0;
            t_sh_q       <= '0;
            t_cmp_q      <= '0;
            cont_q       <= 1'b0;
            center_q     <= '0;
            nbr_q        <= '0;
            idx_q        <= '0;
            code_q       <= '0;
            sh_rst_q     <= 1'b0;
            sh_q         <= 1'b0;
            sh_cmp_q     <= 1'b0;
            sw1_q        <= 1'b0;
            sw2_q        <= 1'b0;
            busy_q       <= 1'b0;
            pd_a_q       <= '0;
            pd_b_q       <= '0;
            lbp_code_q   <= '0;
            code_valid_q <= 1'b0;
            code_pend_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef PIXSEQ_CMP_SYNC_EN
            cmp_sync_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            t_rst_q      <= t_rst_d;
            t_int_q      <= t_int_d;
            t_sh_q       <= t_sh_d;
            t_cmp_q      <= t_cmp_d;
            cont_q       <= cont_d;
            center_q     <= center_d;
            nbr_q        <= nbr_d;
            idx_q        <= idx_d;
            code_q       <= code_d;
            sh_rst_q     <= sh_rst_d;
            sh_q         <= sh_d;
            sh_cmp_q     <= sh_cmp_d;
            sw1_q        <= sw1_d;
            sw2_q        <= sw2_d;
            busy_q       <= busy_d;
            pd_a_q       <= pd_a_d;
            pd_b_q       <= pd_b_d;
            lbp_code_q   <= lbp_code_d;
            code_valid_q <= code_valid_d;
            code_pend_q  <= code_pend_d;
            overrun_q    <= overrun_d;
`ifdef PIXSEQ_CMP_SYNC_EN
            cmp_sync_q   <= {cmp_sync_q[0], cmp_i};
`endif
        end
    end

    assign sh_rst_o             = sh_rst_q;
    assign sh_o                 = sh_q;
    assign sh_cmp_o             = sh_cmp_q;
    assign sw1_o                = sw1_q;
    assign sw2_o                = sw2_q;
    assign pd_a_o               = pd_a_q;
    assign pd_b_o               = pd_b_q;
    assign busy_o               = busy_q;
    assign code_if.lbp_code_o   = lbp_code_q;
    assign code_if.code_valid_o = code_valid_q;
    assign code_if.code_pend_o  = code_pend_q;
    assign code_if.overrun_o    = overrun_q;

endmodule

// File: tb/tb_pixel_seq_ctrl.sv
// Scoreboard bench for pixel_seq_ctrl: expected codes are queued at frame start and
// popped by a monitor on every code_valid pulse; timing and flags checked inline.
module tb_pixel_seq_ctrl;
    localparam int NUM_PD = 12;
    localparam int CNT_W  = 16;
    localparam int IDX_W  = 4;
`ifdef PIXSEQ_CMP_SYNC_EN
    localparam int L = 3;
`else
    localparam int L = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              start_i = 0, abort_i = 0, cont_i = 0, cmp_i;
    logic [CNT_W-1:0]  t_rst_i = 0, t_int_i = 0, t_sh_i = 0, t_cmp_i = 0;
    logic [IDX_W-1:0]  center_i = 0;
    logic [NUM_PD-1:0] chan_mask_i = 0, cmp_pat = 0;
    logic              sh_rst_o, sh_o, sh_cmp_o, sw1_o, sw2_o, busy_o;
    logic [NUM_PD-1:0] pd_a_o, pd_b_o;

    pixel_seq_ctrl_if #(.NUM_PD(NUM_PD)) code_if ();

    pixel_seq_ctrl #(.NUM_PD(NUM_PD), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start_i(start_i), .abort_i(abort_i),
        .cont_i(cont_i), .t_rst_i(t_rst_i), .t_int_i(t_int_i), .t_sh_i(t_sh_i),
        .t_cmp_i(t_cmp_i), .center_i(center_i), .chan_mask_i(chan_mask_i), .cmp_i(cmp_i),
        .sh_rst_o(sh_rst_o), .sh_o(sh_o), .sh_cmp_o(sh_cmp_o), .sw1_o(sw1_o), .sw2_o(sw2_o),
        .pd_a_o(pd_a_o), .pd_b_o(pd_b_o), .busy_o(busy_o), .code_if(code_if)
    );

    // Comparator model: fires when the compare bus selects a pixel in cmp_pat.
    assign cmp_i = |(pd_b_o & cmp_pat);

    logic [63:0] all_outs, strobes;
    assign strobes  = 64'({sh_rst_o, sh_o, sh_cmp_o, sw1_o, sw2_o, pd_a_o, pd_b_o});
    assign all_outs = 64'({sh_rst_o, sh_o, sh_cmp_o, sw1_o, sw2_o, pd_a_o, pd_b_o, busy_o,
                           code_if.lbp_code_o, code_if.code_valid_o, code_if.code_pend_o,
                           code_if.overrun_o});

    int tests_run = 0, tests_failed = 0, valid_cnt = 0;
    logic pdb_seen = 0, pdb_bad = 0;
    logic [NUM_PD-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (pd_b_o != '0) begin
                pdb_seen = 1'b1;
                if (!$onehot(pd_b_o)) pdb_bad = 1'b1;
            end
            if (code_if.code_valid_o) begin
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_valid: got code 0x%0h expected no valid",
                             code_if.lbp_code_o);
                end else begin
                    check("lbp_code", 64'(code_if.lbp_code_o), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic setup(input logic [IDX_W-1:0] c, input logic [NUM_PD-1:0] m,
                         input int t, input logic [NUM_PD-1:0] pat);
        center_i    = c;
        chan_mask_i = m;
        t_rst_i     = CNT_W'(t);
        t_int_i     = CNT_W'(t);
        t_sh_i      = CNT_W'(t);
        t_cmp_i     = CNT_W'(t);
        cmp_pat     = pat;
    endtask

    task automatic pulse_start();
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
    endtask

    task automatic ack();
        code_if.code_ack_i = 1'b1;
        @(negedge clk); code_if.code_ack_i = 1'b0;
    endtask

    // One single-shot frame; config is scrambled after start to prove shadowing.
    task automatic do_frame(input string name, input logic [IDX_W-1:0] c,
                            input logic [NUM_PD-1:0] m, input int t,
                            input logic [NUM_PD-1:0] pat, input logic [NUM_PD-1:0] exp_code,
                            input int exp_len);
        int len;
        setup(c, m, t, pat);
        exp_q.push_back(exp_code);
        pulse_start();
        center_i = 1; chan_mask_i = '0; t_rst_i = 7; t_int_i = 7; t_sh_i = 7; t_cmp_i = 7;
        len = 0;
        while (busy_o && len < 4000) begin
            len++;
            @(negedge clk);
        end
        check({name, "_len"}, 64'(len), 64'(exp_len));
        ack();
    endtask

    initial begin
        int n, cyc, t1, sel_n, vc0, flen;
        logic prev;
        code_if.code_ack_i = 1'b0;

        #1 check("reset_outputs", all_outs, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("idle_outputs", all_outs, 64'd0);

        // Main frame: neighbours 0..11 minus centre 4; comparator high on 0, 5, 11.
        do_frame("main", 4, 12'hFFF, 2, 12'h821, 12'h821, 7 + 11 * (2 + L));
        check("pend_after_ack", 64'(code_if.code_pend_o), 64'd0);

        // Only the centre enabled: no compare phase at all.
        pdb_seen = 1'b0;
        do_frame("no_nbr", 4, 12'h010, 2, 12'hFFF, 12'h000, 7);
        check("no_nbr_pdb_idle", 64'(pdb_seen), 64'd0);

        // Zero durations and out-of-range centre (15 -> 0).
        do_frame("zero_t", 15, 12'hFFF, 0, 12'h00F, 12'h00E, 4 + 11 * (1 + L));

        // Partial mask: masked bits stay 0 even though the comparator is high.
        do_frame("mask", 5, 12'h0F0, 3, 12'hFFF, 12'h0D0, 10 + 3 * (3 + L));

        // Continuous mode, no ack across two frames.
        setup(4, 12'h003, 1, 12'h001);
        flen = 4 + 2 * (1 + L);
        cont_i = 1'b1;
        exp_q.push_back(12'h001);
        exp_q.push_back(12'h001);
        pulse_start();
        n = 0; cyc = 0; t1 = 0;
        while (n < 2 && cyc < 2000) begin
            if (code_if.code_valid_o) begin
                n++;
                if (n == 1) begin
                    t1 = cyc;
                    check("ovr_first", 64'(code_if.overrun_o), 64'd0);
                end else begin
                    check("cont_gap", 64'(cyc - t1), 64'(flen));
                    check("ovr_second", 64'(code_if.overrun_o), 64'd1);
                    check("pend_second", 64'(code_if.code_pend_o), 64'd1);
                end
            end
            if (n < 2) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("cont_valids", 64'(n), 64'd2);
        cont_i = 1'b0; abort_i = 1'b1;
        @(negedge clk); abort_i = 1'b0;
        check("cont_abort_idle", 64'(busy_o), 64'd0);
        ack();
        check("ack_clears", 64'({code_if.code_pend_o, code_if.overrun_o}), 64'd0);

        // Abort in the third SEL.
        setup(4, 12'hFFF, 2, 12'hFFF);
        vc0 = valid_cnt;
        pulse_start();
        sel_n = 0; cyc = 0; prev = 1'b0;
        while (sel_n < 3 && cyc < 1000) begin
            if (sh_cmp_o && !prev) sel_n++;
            prev = sh_cmp_o;
            if (sel_n < 3) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("abort_sel_found", 64'(sel_n), 64'd3);
        abort_i = 1'b1;
        @(negedge clk); abort_i = 1'b0;
        check("abort_busy", 64'(busy_o), 64'd0);
        check("abort_strobes", strobes, 64'd0);
        check("abort_code_kept", 64'(code_if.lbp_code_o), 64'h001);
        repeat (10) @(negedge clk);
        check("abort_no_valid", 64'(valid_cnt - vc0), 64'd0);

        // Abort beats start in the same cycle.
        start_i = 1'b1; abort_i = 1'b1;
        @(negedge clk); start_i = 1'b0; abort_i = 1'b0;
        check("abort_beats_start", 64'(busy_o), 64'd0);

        // Asynchronous reset during SEL, then a clean frame.
        setup(4, 12'hFFF, 2, 12'h821);
        pulse_start();
        cyc = 0;
        while (!sh_cmp_o && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_reached_sel", 64'(sh_cmp_o), 64'd1);
        #2 rst_n = 1'b0;
        #1 check("rst_async", all_outs, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        do_frame("post_rst", 4, 12'hFFF, 2, 12'h821, 12'h821, 7 + 11 * (2 + L));

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("pdb_onehot", 64'(pdb_bad), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
